keccak_arbiter: RTL and testbench
=================================

// Module: keccak_arbiter
// PURPOSE
//  Shares one Keccak core between N_REQ clients (SampleInBall, ExpandA, ExpandMask, ...).
//  Arbitration is round-robin. Only the granted client's start, input state and rho_en reach the core.
//  keccak_done is routed back to that client as a one-cycle done pulse.
//  A lock lets one client keep the core across successive squeezes without re-arbitration.
// PARAMETERS
//  N_REQ         3    number of requesters (2..8)
//  W             1600 Keccak state width
//  LOCK_TIMEOUT  64   cycles in HOLD with lock high and no req before forced release
// PORTS
//  clk            in   1          clock
//  rst_n          in   1          reset, synchronous, active-low
//  req            in   N_REQ      per-client start level; held high until done_out
//  req_lock       in   N_REQ      keep ownership after done (multi-squeeze)
//  req_rho_en     in   N_REQ      per-client rho_en
//  req_data       in   N_REQ*W    per-client Keccak input; slice k = [k*W +: W]
//  grant          out  N_REQ      one-hot owner, 0 when free
//  done_out       out  N_REQ      one-cycle done pulse to owner
//  busy           out  1          core owned (state != IDLE)
//  owner_id       out  3          index of current/last owner
//  keccak_start   out  1          to core start
//  keccak_rho_en  out  1          to core rho_en
//  keccak_in      out  W          to core input
//  keccak_rst_n_o out  1          to core reset (active-low)
//  keccak_done    in   1          from core
// BEHAVIOUR
//  Clock and reset
//  - Single clock clk; reset is synchronous and active-low (rst_n).
//  - Every output is registered.
//  - Reset values: all outputs 0, including keccak_rst_n_o (core held in reset). ptr=0, state=IDLE, timeout counter=0.
//  - Reset asserted mid-transfer: everything returns to reset values on the next edge. No done_out is issued.
//  State machine
//  - IDLE: grant=0, start=0, keccak_rst_n_o=0.
//    - If req!=0, pick the first set bit searching ptr, ptr+1, ... mod N_REQ.
//    - Register grant, owner_id, keccak_in=req_data[owner], keccak_rho_en=req_rho_en[owner]. Go to ARM.
//  - ARM (1 cycle): keccak_rst_n_o=0, keccak_start=0. Go to RUN.
//  - RUN: keccak_rst_n_o=1, keccak_start=1. keccak_in/rho_en are held (latched values).
//    - keccak_done=1: next cycle done_out[owner]=1 for exactly 1 cycle, start=0, go to HOLD.
//    - req[owner]=0 before done (abort): next cycle keccak_rst_n_o=0, start=0, go to IDLE, ptr=owner+1. No done_out.
//    - Abort and keccak_done in the same cycle: done takes priority (treated as completion).
//  - HOLD: start=0, keccak_rst_n_o=0.
//    - req_lock[owner]=1 and req[owner]=1: relatch data/rho_en from owner, go to ARM. Same owner, no arbitration.
//    - req_lock[owner]=0: release. grant=0, ptr=(owner+1) mod N_REQ, go to IDLE.
//    - Lock held, no req: timeout counter increments each cycle. At LOCK_TIMEOUT it releases as above.
//    - Counter clears on leaving HOLD.
//  Latencies and sizing
//  - Latency from req sampled in IDLE to keccak_start: 2 cycles (IDLE->ARM->RUN).
//  - keccak_done to done_out: 1 cycle.
//  - A client in HOLD must drop req within one cycle of done_out unless it re-requests.
//  - Requests arriving while busy wait; they are never lost while held.
//  - ptr wraps from N_REQ-1 to 0.
//  - owner_id width 3 covers N_REQ<=8; unused grant bits are tied 0.
// TESTING
//  T1 single: req=001 with data D0 -> grant=001 at +1, rst_n_o low at +1, start at +2. keccak_done -> done_out=001 for 1 cycle; idle after lock=0.
//  T2 fairness: req=111 held, lock=0, 6 transfers -> grant order 001,010,100,001,010,100.
//  T3 lock: client1 lock=1, 4 squeezes -> 4 done_out pulses to client1. Client0 and client2 are not granted until client1 drops lock.
//  T4 abort: owner drops req mid-RUN -> start=0 and rst_n_o=0 next cycle, no done_out, ptr advances.
//  T5 timeout: lock=1, req=0 in HOLD -> release after exactly 64 cycles; pending req=100 then granted.
//  T6 reset: rst_n=0 during RUN -> next edge all outputs 0. Later req=010 is granted first (ptr=0 search finds 1).

Source files
------------

// File: rtl/keccak_arbiter.sv
// keccak_arbiter: shares one Keccak core between N_REQ clients.
//   Round-robin arbitration picks an owner. Only that owner's start, state and
//   rho_en reach the core. keccak_done comes back to the owner as a one-cycle
//   done pulse. A lock lets the owner keep the core across successive squeezes.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   req             per-client start level, held until done_out
//   req_lock        per-client keep-ownership request (multi-squeeze)
//   req_rho_en      per-client rho_en
//   req_data        per-client Keccak input, slice k = [k*W +: W]
//   grant           one-hot owner, 0 when free
//   done_out        one-cycle done pulse to owner
//   busy            core owned (state != IDLE)
//   owner_id        index of current/last owner
//   keccak_start    core start
//   keccak_rho_en   core rho_en
//   keccak_in       core input state
//   keccak_rst_n_o  core reset, active-low
//   keccak_done     core completion
module keccak_arbiter #(
    parameter int unsigned N_REQ        = 3,
    parameter int unsigned W            = 1600,
    parameter int unsigned LOCK_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ-1:0]   req_lock,
    input  logic [N_REQ-1:0]   req_rho_en,
    input  logic [N_REQ*W-1:0] req_data,
    output logic [N_REQ-1:0]   grant,
    output logic [N_REQ-1:0]   done_out,
    output logic               busy,
    output logic [2:0]         owner_id,
    output logic               keccak_start,
    output logic               keccak_rho_en,
    output logic [W-1:0]       keccak_in,
    output logic               keccak_rst_n_o,
    input  logic               keccak_done
);

    localparam int unsigned CW = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_HOLD} state_t;

    state_t             state_q;
    logic [2:0]         ptr_q;
    logic [CW-1:0]      cnt_q;
    logic [N_REQ-1:0]   grant_q;
    logic [N_REQ-1:0]   done_q;
    logic               busy_q;
    logic [2:0]         owner_q;
    logic               start_q;
    logic               rho_q;
    logic [W-1:0]       in_q;
    logic               krst_n_q;

    // Combinational arbitration and owner-side selection
    logic               pick_vld_d;
    logic [2:0]         pick_id_d;
    logic [N_REQ-1:0]   pick_oh_d;
    logic [W-1:0]       pick_data_d;
    logic               pick_rho_d;
    logic               own_req_d;
    logic               own_lock_d;
    logic [W-1:0]       own_data_d;
    logic               own_rho_d;
    logic [2:0]         ptr_d;

    always_comb begin
        pick_vld_d  = 1'b0;
        pick_id_d   = '0;
        pick_oh_d   = '0;
        pick_data_d = '0;
        pick_rho_d  = 1'b0;
        own_req_d   = 1'b0;
        own_lock_d  = 1'b0;
        own_data_d  = '0;
        own_rho_d   = 1'b0;
        // Search ptr, ptr+1, ... mod N_REQ; the inner loop maps the rotated
        // offset back to a constant client index so every select is static.
        for (int unsigned off = 0; off < N_REQ; off++) begin
            for (int unsigned j = 0; j < N_REQ; j++) begin
                if (!pick_vld_d && req[j] && ((32'(ptr_q) + off) % N_REQ) == j) begin
                    pick_vld_d = 1'b1;
                    pick_id_d  = 3'(j);
                end
            end
        end
        for (int unsigned j = 0; j < N_REQ; j++) begin
            if (pick_id_d == 3'(j)) begin
                pick_oh_d[j] = 1'b1;
                pick_data_d  = req_data[j*W +: W];
                pick_rho_d   = req_rho_en[j];
            end
            if (owner_q == 3'(j)) begin
                own_req_d  = req[j];
                own_lock_d = req_lock[j];
                own_data_d = req_data[j*W +: W];
                own_rho_d  = req_rho_en[j];
            end
        end
        ptr_d = (owner_q == 3'(N_REQ - 1)) ? 3'd0 : owner_q + 3'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            cnt_q    <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            busy_q   <= 1'b0;
            owner_q  <= '0;
            start_q  <= 1'b0;
            rho_q    <= 1'b0;
            in_q     <= '0;
            krst_n_q <= 1'b0;
        end else begin
            done_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (pick_vld_d) begin
                        grant_q <= pick_oh_d;
                        owner_q <= pick_id_d;
                        in_q    <= pick_data_d;
                        rho_q   <= pick_rho_d;
                        busy_q  <= 1'b1;
                        state_q <= S_ARM;
                    end
                end
                S_ARM: begin
                    start_q  <= 1'b1;
                    krst_n_q <= 1'b1;
                    state_q  <= S_RUN;
                end
                S_RUN: begin
                    // Completion wins over a simultaneous abort.
                    if (keccak_done) begin
                        done_q   <= grant_q;
                        start_q  <= 1'b0;
                        krst_n_q <= 1'b0;
                        state_q  <= S_HOLD;
                    end else if (!own_req_d) begin
                        start_q  <= 1'b0;
                        krst_n_q <= 1'b0;
                        grant_q  <= '0;
                        busy_q   <= 1'b0;
                        ptr_q    <= ptr_d;
                        state_q  <= S_IDLE;
                    end
                end
                S_HOLD: begin
                    if (own_lock_d && own_req_d) begin
                        in_q    <= own_data_d;
                        rho_q   <= own_rho_d;
                        cnt_q   <= '0;
                        state_q <= S_ARM;
                    end else if (!own_lock_d || cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        ptr_q   <= ptr_d;
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign grant          = grant_q;
    assign done_out       = done_q;
    assign busy           = busy_q;
    assign owner_id       = owner_q;
    assign keccak_start   = start_q;
    assign keccak_rho_en  = rho_q;
    assign keccak_in      = in_q;
    assign keccak_rst_n_o = krst_n_q;

endmodule

// File: tb/tb_keccak_arbiter.sv
// tb_keccak_arbiter: directed bench for keccak_arbiter (3 clients, 16-bit state).
module tb_keccak_arbiter;

    localparam int unsigned NR = 3;
    localparam int unsigned WD = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR-1:0]    req, req_lock, req_rho_en;
    logic [NR*WD-1:0] req_data;
    logic [NR-1:0]    grant, done_out;
    logic             busy;
    logic [2:0]       owner_id;
    logic             keccak_start, keccak_rho_en, keccak_rst_n_o, keccak_done;
    logic [WD-1:0]    keccak_in;

    logic [WD-1:0]    dtab [NR];
    int               n_total = 0;
    int               n_bad   = 0;

    keccak_arbiter #(.N_REQ(NR), .W(WD), .LOCK_TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_lock(req_lock),
        .req_rho_en(req_rho_en), .req_data(req_data), .grant(grant),
        .done_out(done_out), .busy(busy), .owner_id(owner_id),
        .keccak_start(keccak_start), .keccak_rho_en(keccak_rho_en),
        .keccak_in(keccak_in), .keccak_rst_n_o(keccak_rst_n_o),
        .keccak_done(keccak_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_data();
        req_data = {dtab[2], dtab[1], dtab[0]};
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; req = '0; req_lock = '0; keccak_done = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    // One transfer for client c: wait (bounded) for grant, check latched
    // inputs, step into RUN, pulse keccak_done and check the done pulse.
    task automatic do_xfer(input string tag, input int c);
        logic [2:0] eg;
        int k;
        eg = 3'(1 << c);
        k  = 0;
        step(1);
        while (grant == '0 && k < 8) begin
            step(1);
            k++;
        end
        check({tag, " grant"}, 32'(grant), 32'(eg));
        check({tag, " owner"}, 32'(owner_id), 32'(c));
        check({tag, " kin"},   32'(keccak_in), 32'(dtab[c]));
        check({tag, " rho"},   32'(keccak_rho_en), 32'(req_rho_en[c]));
        step(1);
        check({tag, " start"}, 32'(keccak_start), 32'd1);
        keccak_done = 1'b1;
        step(1);
        keccak_done = 1'b0;
        check({tag, " done"}, 32'(done_out), 32'(eg));
    endtask

    initial begin
        dtab[0] = 16'hA0A0; dtab[1] = 16'hB1B1; dtab[2] = 16'hC2C2;
        set_data();
        req_rho_en = 3'b101;
        rst_n = 1'b0; req = '0; req_lock = '0; keccak_done = 1'b0;
        step(2);
        check("rst grant", 32'(grant), 32'd0);
        check("rst done",  32'(done_out), 32'd0);
        check("rst busy",  32'(busy), 32'd0);
        check("rst owner", 32'(owner_id), 32'd0);
        check("rst start", 32'(keccak_start), 32'd0);
        check("rst rho",   32'(keccak_rho_en), 32'd0);
        check("rst kin",   32'(keccak_in), 32'd0);
        check("rst crst",  32'(keccak_rst_n_o), 32'd0);
        rst_n = 1'b1;
        step(1);

        // T1 single transfer, explicit latencies
        req = 3'b001;
        step(1);
        check("t1 grant+1", 32'(grant), 32'd1);
        check("t1 crst+1",  32'(keccak_rst_n_o), 32'd0);
        check("t1 start+1", 32'(keccak_start), 32'd0);
        check("t1 busy",    32'(busy), 32'd1);
        check("t1 kin",     32'(keccak_in), 32'hA0A0);
        check("t1 rho",     32'(keccak_rho_en), 32'd1);
        step(1);
        check("t1 start+2", 32'(keccak_start), 32'd1);
        check("t1 crst+2",  32'(keccak_rst_n_o), 32'd1);
        step(2);
        check("t1 start held", 32'(keccak_start), 32'd1);
        check("t1 no early done", 32'(done_out), 32'd0);
        keccak_done = 1'b1;
        step(1);
        keccak_done = 1'b0;
        req = 3'b000;
        check("t1 done",      32'(done_out), 32'd1);
        check("t1 start off", 32'(keccak_start), 32'd0);
        check("t1 crst off",  32'(keccak_rst_n_o), 32'd0);
        step(1);
        check("t1 done 1cyc", 32'(done_out), 32'd0);
        check("t1 released",  32'(grant), 32'd0);
        check("t1 idle",      32'(busy), 32'd0);

        // T2 round-robin fairness
        apply_reset();
        req = 3'b111;
        for (int i = 0; i < 6; i++) do_xfer("t2", i % 3);
        req = 3'b000;
        step(1);
        check("t2 idle", 32'(busy), 32'd0);

        // T3 lock: client1 keeps the core for 4 squeezes, data relatched each time
        apply_reset();
        req = 3'b010; req_lock = 3'b010;
        for (int i = 0; i < 4; i++) begin
            do_xfer("t3", 1);
            if (i < 3) begin
                req = 3'b111;
                dtab[1] = dtab[1] + 16'd1;
                set_data();
            end
        end
        req_lock = 3'b000; req = 3'b101;
        step(1);
        check("t3 release", 32'(grant), 32'd0);
        do_xfer("t3 next", 2);
        req = 3'b000;
        step(2);

        // T4 abort, then abort coinciding with done
        apply_reset();
        req = 3'b001;
        step(2);
        check("t4 run", 32'(keccak_start), 32'd1);
        req = 3'b000;
        step(1);
        check("t4 start off", 32'(keccak_start), 32'd0);
        check("t4 crst off",  32'(keccak_rst_n_o), 32'd0);
        check("t4 grant off", 32'(grant), 32'd0);
        check("t4 no done",   32'(done_out), 32'd0);
        check("t4 not busy",  32'(busy), 32'd0);
        req = 3'b011;
        step(1);
        check("t4 ptr adv", 32'(grant), 32'd2);
        step(1);
        req = 3'b000; keccak_done = 1'b1;
        step(1);
        keccak_done = 1'b0;
        check("t4 done prio", 32'(done_out), 32'd2);
        step(2);

        // T5 lock timeout
        apply_reset();
        req = 3'b001; req_lock = 3'b001;
        do_xfer("t5", 0);
        req = 3'b100;
        step(63);
        check("t5 held 63", 32'(grant), 32'd1);
        check("t5 busy 63", 32'(busy), 32'd1);
        step(1);
        check("t5 release 64", 32'(grant), 32'd0);
        step(1);
        check("t5 pending", 32'(grant), 32'd4);
        req_lock = 3'b000;

        // T6 reset during RUN
        step(1);
        check("t6 run", 32'(keccak_start), 32'd1);
        rst_n = 1'b0; keccak_done = 1'b1;
        step(1);
        check("t6 grant", 32'(grant), 32'd0);
        check("t6 done",  32'(done_out), 32'd0);
        check("t6 busy",  32'(busy), 32'd0);
        check("t6 owner", 32'(owner_id), 32'd0);
        check("t6 start", 32'(keccak_start), 32'd0);
        check("t6 rho",   32'(keccak_rho_en), 32'd0);
        check("t6 kin",   32'(keccak_in), 32'd0);
        check("t6 crst",  32'(keccak_rst_n_o), 32'd0);
        keccak_done = 1'b0; rst_n = 1'b1; req = 3'b110;
        step(1);
        check("t6 regrant", 32'(grant), 32'd2);
        check("t6 no done", 32'(done_out), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
